alu_issue_stage: RTL and testbench

//   ID/EX boundary stage that feeds the combinational RV32IM ALU. Registers a decoded

---
 rtl/alu_issue_pkg.sv | 63 ++++++
 rtl/alu_issue_stage_fwd.sv | 26 ++
 rtl/alu_issue_stage.sv | 200 ++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared encodings and the issue-entry record for the ALU issue stage.
// The ALU_ISSUE_SKID_EN build option is consumed by alu_issue_stage.
package alu_issue_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int SEL_W  = 5;

  // Operand source selects
  localparam logic OP1_RS1 = 1'b0;
  localparam logic OP1_PC  = 1'b1;
  localparam logic OP2_RS2 = 1'b0;
  localparam logic OP2_IMM = 1'b1;

  // ALU SELECT codes: {func7[0], func7[5], func3}
  typedef enum logic [SEL_W-1:0] {
    ALU_ADD    = 5'b00000,
    ALU_SLL    = 5'b00001,
    ALU_SLT    = 5'b00010,
    ALU_SLTU   = 5'b00011,
    ALU_XOR    = 5'b00100,
    ALU_SRL    = 5'b00101,
    ALU_OR     = 5'b00110,
    ALU_AND    = 5'b00111,
    ALU_SUB    = 5'b01000,
    ALU_SRA    = 5'b01101,
    ALU_MUL    = 5'b10000,
    ALU_MULH   = 5'b10001,
    ALU_MULHSU = 5'b10010,
    ALU_MULHU  = 5'b10011,
    ALU_DIV    = 5'b10100,
    ALU_DIVU   = 5'b10101,
    ALU_REM    = 5'b10110,
    ALU_REMU   = 5'b10111
  } alu_sel_e;

  // One instruction as held in the stage. data1/data2 already carry the
  // selected operand (PC/IMM or register value).
  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic              op1_sel;
    logic              op2_sel;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data1;
    logic [XLEN-1:0]   data2;
    logic [XLEN-1:0]   pc;
  } entry_t;

  // Replace register-sourced operands with their forwarded values;
  // PC/IMM operands pass through untouched.
  function automatic entry_t resolve(input entry_t e,
                                     input logic [XLEN-1:0] fwd1,
                                     input logic [XLEN-1:0] fwd2);
    entry_t r;
    r = e;
    if (e.op1_sel == OP1_RS1) r.data1 = fwd1;
    if (e.op2_sel == OP2_RS2) r.data2 = fwd2;
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_stage_fwd.sv
// Combinational forwarding mux: EX/MEM beats MEM/WB, x0 is never forwarded.
module alu_fwd_mux
  import alu_issue_pkg::*;
(
  input  logic [REG_AW-1:0] addr,
  input  logic [XLEN-1:0]   rf,
  input  logic              exm_we,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              mwb_we,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [XLEN-1:0]   mwb_data,
  output logic [XLEN-1:0]   data
);

  // Priority select of the freshest producer of addr
  always_comb begin
    data = rf;
    if (exm_we && (exm_rd == addr) && (addr != '0)) begin
      data = exm_data;
    end else if (mwb_we && (mwb_rd == addr) && (addr != '0)) begin
      data = mwb_data;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage feeding the ALU: operand select, RAW forwarding,
// valid/ready handshake with flush and stall-time operand refresh.
// Build option ALU_ISSUE_SKID_EN adds a 1-entry skid buffer and a
// registered IN_READY.
module alu_issue_stage
  import alu_issue_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [SEL_W-1:0]  IN_SELECT,
  input  logic              IN_OP1_SEL,
  input  logic              IN_OP2_SEL,
  input  logic [REG_AW-1:0] IN_RS1_ADDR,
  input  logic [REG_AW-1:0] IN_RS2_ADDR,
  input  logic [REG_AW-1:0] IN_RD_ADDR,
  input  logic [XLEN-1:0]   IN_RS1_DATA,
  input  logic [XLEN-1:0]   IN_RS2_DATA,
  input  logic [XLEN-1:0]   IN_IMM,
  input  logic [XLEN-1:0]   IN_PC,
  input  logic              EXM_WE,
  input  logic [REG_AW-1:0] EXM_RD,
  input  logic [XLEN-1:0]   EXM_DATA,
  input  logic              MWB_WE,
  input  logic [REG_AW-1:0] MWB_RD,
  input  logic [XLEN-1:0]   MWB_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [XLEN-1:0]   DATA1,
  output logic [XLEN-1:0]   DATA2,
  output logic [SEL_W-1:0]  SELECT,
  output logic [REG_AW-1:0] OUT_RD_ADDR,
  output logic [XLEN-1:0]   OUT_PC
);

  entry_t in_entry, main_reg, main_next, main_src, main_res;
  logic   out_valid_reg, out_valid_next;
  logic   advance, accept;

  logic [REG_AW-1:0] main_addr [2];
  logic [XLEN-1:0]   main_rf   [2];
  logic [XLEN-1:0]   main_fwd  [2];

  // Incoming instruction with PC/IMM already substituted
  always_comb begin
    in_entry         = '0;
    in_entry.sel     = IN_SELECT;
    in_entry.op1_sel = IN_OP1_SEL;
    in_entry.op2_sel = IN_OP2_SEL;
    in_entry.rs1     = IN_RS1_ADDR;
    in_entry.rs2     = IN_RS2_ADDR;
    in_entry.rd      = IN_RD_ADDR;
    in_entry.data1   = (IN_OP1_SEL == OP1_PC)  ? IN_PC  : IN_RS1_DATA;
    in_entry.data2   = (IN_OP2_SEL == OP2_IMM) ? IN_IMM : IN_RS2_DATA;
    in_entry.pc      = IN_PC;
  end

  assign advance = !out_valid_reg || OUT_READY;
  assign accept  = IN_VALID && IN_READY;

  // Main muxes see the incoming entry when the output advances, otherwise
  // the held entry so its operands are refreshed in place.
  assign main_src     = advance ? in_entry : main_reg;
  assign main_addr[0] = main_src.rs1;
  assign main_addr[1] = main_src.rs2;
  assign main_rf[0]   = main_src.data1;
  assign main_rf[1]   = main_src.data2;
  assign main_res     = resolve(main_src, main_fwd[0], main_fwd[1]);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_main_fwd
      alu_fwd_mux u_fwd (
        .addr     (main_addr[gi]),
        .rf       (main_rf[gi]),
        .exm_we   (EXM_WE),
        .exm_rd   (EXM_RD),
        .exm_data (EXM_DATA),
        .mwb_we   (MWB_WE),
        .mwb_rd   (MWB_RD),
        .mwb_data (MWB_DATA),
        .data     (main_fwd[gi])
      );
    end
  endgenerate

`ifdef ALU_ISSUE_SKID_EN
  entry_t skid_reg, skid_next, skid_src, skid_res;
  logic   skid_full_reg, skid_full_next;
  logic   in_ready_reg;

  logic [REG_AW-1:0] skid_addr [2];
  logic [XLEN-1:0]   skid_rf   [2];
  logic [XLEN-1:0]   skid_fwd  [2];

  // Skid muxes refresh a parked entry, or capture the incoming one when empty
  assign skid_src     = skid_full_reg ? skid_reg : in_entry;
  assign skid_addr[0] = skid_src.rs1;
  assign skid_addr[1] = skid_src.rs2;
  assign skid_rf[0]   = skid_src.data1;
  assign skid_rf[1]   = skid_src.data2;
  assign skid_res     = resolve(skid_src, skid_fwd[0], skid_fwd[1]);

  generate
    for (gi = 0; gi < 2; gi++) begin : g_skid_fwd
      alu_fwd_mux u_fwd (
        .addr     (skid_addr[gi]),
        .rf       (skid_rf[gi]),
        .exm_we   (EXM_WE),
        .exm_rd   (EXM_RD),
        .exm_data (EXM_DATA),
        .mwb_we   (MWB_WE),
        .mwb_rd   (MWB_RD),
        .mwb_data (MWB_DATA),
        .data     (skid_fwd[gi])
      );
    end
  endgenerate

  // IN_READY comes straight from a flop: no path from OUT_READY
  assign IN_READY = in_ready_reg;

  // Next-state for main output register and skid entry
  always_comb begin
    main_next      = main_reg;
    out_valid_next = out_valid_reg;
    skid_next      = skid_reg;
    skid_full_next = skid_full_reg;
    if (FLUSH) begin
      out_valid_next = 1'b0;
      skid_full_next = 1'b0;
    end else if (advance) begin
      if (skid_full_reg) begin
        main_next      = skid_res;
        out_valid_next = 1'b1;
        skid_full_next = 1'b0;
      end else begin
        out_valid_next = accept;
        if (accept) main_next = main_res;
      end
    end else begin
      main_next = main_res;
      if (skid_full_reg || accept) begin
        skid_next      = skid_res;
        skid_full_next = 1'b1;
      end
    end
  end

  // Skid entry and registered ready
  always_ff @(posedge CLK) begin
    if (RESET) begin
      skid_reg      <= '0;
      skid_full_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      skid_reg      <= skid_next;
      skid_full_reg <= skid_full_next;
      in_ready_reg  <= !skid_full_next;
    end
  end
`else
  assign IN_READY = !out_valid_reg || OUT_READY;

  // Next-state for the output register: load, refresh or hold
  always_comb begin
    main_next      = main_reg;
    out_valid_next = out_valid_reg;
    if (FLUSH) begin
      out_valid_next = 1'b0;
    end else if (advance) begin
      out_valid_next = accept;
      if (accept) main_next = main_res;
    end else begin
      main_next = main_res;
    end
  end
`endif

  // Output register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      main_reg      <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      main_reg      <= main_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign OUT_VALID   = out_valid_reg;
  assign DATA1       = main_reg.data1;
  assign DATA2       = main_reg.data2;
  assign SELECT      = main_reg.sel;
  assign OUT_RD_ADDR = main_reg.rd;
  assign OUT_PC      = main_reg.pc;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed vectors push expected
// results, a forked monitor pops and compares on every out-transfer.
module tb_alu_issue_stage;
  import alu_issue_pkg::*;

  logic              CLK = 1'b0;
  logic              RESET, FLUSH, IN_VALID, IN_READY;
  logic [SEL_W-1:0]  IN_SELECT;
  logic              IN_OP1_SEL, IN_OP2_SEL;
  logic [REG_AW-1:0] IN_RS1_ADDR, IN_RS2_ADDR, IN_RD_ADDR;
  logic [XLEN-1:0]   IN_RS1_DATA, IN_RS2_DATA, IN_IMM, IN_PC;
  logic              EXM_WE, MWB_WE;
  logic [REG_AW-1:0] EXM_RD, MWB_RD;
  logic [XLEN-1:0]   EXM_DATA, MWB_DATA;
  logic              OUT_VALID, OUT_READY;
  logic [XLEN-1:0]   DATA1, DATA2, OUT_PC;
  logic [SEL_W-1:0]  SELECT;
  logic [REG_AW-1:0] OUT_RD_ADDR;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] pc;
    logic [4:0]  sel;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   emitted = 0;
  int   tracked = 0;
  bit   rand_en = 1'b0;

  alu_issue_stage dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_SELECT(IN_SELECT),
    .IN_OP1_SEL(IN_OP1_SEL), .IN_OP2_SEL(IN_OP2_SEL),
    .IN_RS1_ADDR(IN_RS1_ADDR), .IN_RS2_ADDR(IN_RS2_ADDR), .IN_RD_ADDR(IN_RD_ADDR),
    .IN_RS1_DATA(IN_RS1_DATA), .IN_RS2_DATA(IN_RS2_DATA), .IN_IMM(IN_IMM), .IN_PC(IN_PC),
    .EXM_WE(EXM_WE), .EXM_RD(EXM_RD), .EXM_DATA(EXM_DATA),
    .MWB_WE(MWB_WE), .MWB_RD(MWB_RD), .MWB_DATA(MWB_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT),
    .OUT_RD_ADDR(OUT_RD_ADDR), .OUT_PC(OUT_PC)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  // Offer one instruction and wait (bounded) until it is accepted
  task automatic send(input logic [4:0] sel, input logic o1, input logic o2,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic [31:0] imm, input logic [31:0] pc,
                      input logic [31:0] e1, input logic [31:0] e2, input bit track);
    bit got;
    int n;
    exp_t e;
    IN_SELECT = sel; IN_OP1_SEL = o1; IN_OP2_SEL = o2;
    IN_RS1_ADDR = rs1; IN_RS2_ADDR = rs2; IN_RD_ADDR = rd;
    IN_RS1_DATA = d1; IN_RS2_DATA = d2; IN_IMM = imm; IN_PC = pc;
    IN_VALID = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 50) begin
      @(negedge CLK);
      got = (IN_READY === 1'b1);
      @(posedge CLK);
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=0 want=1 rd=%0d", rd);
    end else if (track) begin
      e.d1 = e1; e.d2 = e2; e.pc = pc; e.sel = sel; e.rd = rd;
      exp_q.push_back(e);
      tracked++;
    end
    #1;
    IN_VALID = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    IN_SELECT = '0; IN_OP1_SEL = 1'b0; IN_OP2_SEL = 1'b0;
    IN_RS1_ADDR = '0; IN_RS2_ADDR = '0; IN_RD_ADDR = '0;
    IN_RS1_DATA = '0; IN_RS2_DATA = '0; IN_IMM = '0; IN_PC = '0;
    EXM_WE = 1'b0; EXM_RD = '0; EXM_DATA = '0;
    MWB_WE = 1'b0; MWB_RD = '0; MWB_DATA = '0;

    fork
      // Monitor: one comparison set per out-transfer
      forever begin
        @(negedge CLK);
        if (RESET === 1'b0 && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output got rd=%0d d1=%h want=none", OUT_RD_ADDR, DATA1);
          end else begin
            mon_e = exp_q.pop_front();
            emitted++;
            $display("txn %0d rd=%0d sel=%0h d1=%h d2=%h pc=%h",
                     emitted, OUT_RD_ADDR, SELECT, DATA1, DATA2, OUT_PC);
            chk("data1", DATA1, mon_e.d1);
            chk("data2", DATA2, mon_e.d2);
            chk("select", {27'd0, SELECT}, {27'd0, mon_e.sel});
            chk("rd", {27'd0, OUT_RD_ADDR}, {27'd0, mon_e.rd});
            chk("pc", OUT_PC, mon_e.pc);
          end
        end
      end
      // Random downstream backpressure
      forever begin
        @(posedge CLK);
        #1;
        if (rand_en) OUT_READY = 1'($urandom_range(0, 1));
      end
    join_none

    // 1. Reset and idle outputs
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("rst_in_ready", {31'd0, IN_READY}, 32'd1);
    chk("rst_data1", DATA1, 32'd0);
    chk("rst_data2", DATA2, 32'd0);
    chk("rst_select", {27'd0, SELECT}, 32'd0);
`ifdef ALU_ISSUE_SKID_EN
    begin
      logic r0;
      r0 = IN_READY;
      OUT_READY = 1'b0;
      #1 chk("ready_indep", {31'd0, IN_READY}, {31'd0, r0});
      OUT_READY = 1'b1;
    end
`endif
    @(posedge CLK); #1;

    // 2. ADD x5 + imm 7, one-cycle latency
    send(ALU_ADD, OP1_RS1, OP2_IMM, 5'd5, 5'd0, 5'd1, 32'd10, 32'd0, 32'd7, 32'h100,
         32'd10, 32'd7, 1'b1);
    @(negedge CLK);
    chk("latency_valid", {31'd0, OUT_VALID}, 32'd1);
    @(posedge CLK); #1;

    // 3. Forwarding priority, x0 protection, MEM/WB-only match
    EXM_WE = 1'b1; EXM_RD = 5'd3; EXM_DATA = 32'hAA;
    MWB_WE = 1'b1; MWB_RD = 5'd3; MWB_DATA = 32'hBB;
    send(ALU_XOR, OP1_RS1, OP2_RS2, 5'd3, 5'd6, 5'd2, 32'h11, 32'h22, 32'd0, 32'h104,
         32'hAA, 32'h22, 1'b1);
    EXM_RD = 5'd0;
    send(ALU_OR, OP1_RS1, OP2_RS2, 5'd0, 5'd6, 5'd3, 32'h0, 32'h22, 32'd0, 32'h108,
         32'h0, 32'h22, 1'b1);
    EXM_WE = 1'b0; MWB_RD = 5'd7; MWB_DATA = 32'hCC;
    send(ALU_AND, OP1_RS1, OP2_RS2, 5'd6, 5'd7, 5'd4, 32'h33, 32'h44, 32'd0, 32'h10C,
         32'h33, 32'hCC, 1'b1);
    MWB_WE = 1'b0;
    repeat (2) @(posedge CLK); #1;

    // 4. Stall, then MEM/WB refresh of a held register operand
    OUT_READY = 1'b0;
    send(ALU_SUB, OP1_RS1, OP2_RS2, 5'd2, 5'd4, 5'd5, 32'h20, 32'h44, 32'd0, 32'h110,
         32'h20, 32'h55, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("stall_select", {27'd0, SELECT}, {27'd0, ALU_SUB});
      chk("stall_data2", DATA2, 32'h44);
    end
    @(posedge CLK); #1;
    MWB_WE = 1'b1; MWB_RD = 5'd4; MWB_DATA = 32'h55;
    @(posedge CLK); #1;
    MWB_WE = 1'b0;
    @(negedge CLK);
    chk("refresh_data2", DATA2, 32'h55);
    chk("refresh_data1", DATA1, 32'h20);
    chk("refresh_select", {27'd0, SELECT}, {27'd0, ALU_SUB});
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    repeat (2) @(posedge CLK); #1;

    // 4b. PC/IMM operands are never refreshed while held
    OUT_READY = 1'b0;
    send(ALU_ADD, OP1_PC, OP2_IMM, 5'd4, 5'd4, 5'd8, 32'h1, 32'h2, 32'h9, 32'h200,
         32'h200, 32'h9, 1'b1);
    EXM_WE = 1'b1; EXM_RD = 5'd4; EXM_DATA = 32'h77;
    @(posedge CLK); #1;
    EXM_WE = 1'b0;
    @(negedge CLK);
    chk("imm_held", DATA2, 32'h9);
    chk("pc_held", DATA1, 32'h200);
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    repeat (2) @(posedge CLK); #1;

    // 5. Flush with a held entry and an offered instruction
    OUT_READY = 1'b0;
    send(ALU_SLL, OP1_RS1, OP2_RS2, 5'd1, 5'd2, 5'd9, 32'h1, 32'h2, 32'd0, 32'h300,
         32'h1, 32'h2, 1'b0);
    IN_SELECT = ALU_SRA; IN_RD_ADDR = 5'd10; IN_PC = 32'h304; IN_VALID = 1'b1;
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0; IN_VALID = 1'b0;
    @(negedge CLK);
    chk("flush_held_valid", {31'd0, OUT_VALID}, 32'd0);
    OUT_READY = 1'b1;
    repeat (3) @(posedge CLK); #1;
    IN_SELECT = ALU_SLT; IN_RD_ADDR = 5'd11; IN_PC = 32'h308; IN_VALID = 1'b1;
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0; IN_VALID = 1'b0;
    @(negedge CLK);
    chk("flush_in_valid", {31'd0, OUT_VALID}, 32'd0);
    repeat (3) @(posedge CLK); #1;

    // 6. Stream of 8 ops under random backpressure
    rand_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] d1;
      logic [31:0] d2;
      d1 = 32'(i * 3 + 1);
      d2 = 32'(i + 100);
      if (i % 2 == 0)
        send(ALU_ADD, OP1_RS1, OP2_IMM, 5'd12, 5'd13, 5'(i + 16), d1, 32'hDEAD, d2,
             32'(32'h400 + 4 * i), d1, d2, 1'b1);
      else
        send(ALU_MUL, OP1_RS1, OP2_RS2, 5'd12, 5'd13, 5'(i + 16), d1, d2, 32'hBEEF,
             32'(32'h400 + 4 * i), d1, d2, 1'b1);
    end
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(posedge CLK);
    #1;
    rand_en = 1'b0;
    OUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("emitted_count", 32'(emitted), 32'(tracked));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
